// File: rtl/scr86_pkg.sv
// Shared constants, FSM encoding and the 86-bit / 15-bit-per-step scrambler step function.
package scr86_pkg;

  localparam int unsigned ST_W     = 86;
  localparam int unsigned CHUNK    = 15;
  localparam int unsigned NUM_TAPS = 5;

  localparam int unsigned TAPS [NUM_TAPS] = '{32, 47, 56, 65, 78};

  typedef enum logic [1:0] {
    StIdle,
    StReady,
    StActive
  } fsm_e;

  function automatic logic [ST_W-1:0] build_tap_mask();
    logic [ST_W-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      m = m | (ST_W'(1) << TAPS[i]);
    end
    return m;
  endfunction

  localparam logic [ST_W-1:0] TAP_MASK = build_tap_mask();

  // Shifts word bit 0 first; the feedback bit is XORed into bit 0 and every tap.
  function automatic logic [ST_W-1:0] scr_step(input logic [ST_W-1:0] s,
                                               input logic [CHUNK-1:0] word);
    logic [ST_W-1:0] cur;
    logic            msb;
    cur = s;
    for (int k = 0; k < CHUNK; k++) begin
      msb = cur[ST_W-1];
      cur = {cur[ST_W-2:0], msb ^ word[k]} ^ ({ST_W{msb}} & TAP_MASK);
    end
    return cur;
  endfunction

endpackage

// File: rtl/scr86_stream_ctrl_if.sv
// Input/output word streams of the scrambler controller.
interface scr86_stream_ctrl_if;
  import scr86_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CHUNK-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CHUNK-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/scr86_step.sv
// One scrambler step: next state plus the scrambled word taken from its low bits.
module scr86_step
  import scr86_pkg::*;
(
  input  logic [ST_W-1:0]  state_cur,
  input  logic [CHUNK-1:0] word,
  output logic [ST_W-1:0]  state_nxt,
  output logic [CHUNK-1:0] scr_word
);

  always_comb begin
    state_nxt = scr_step(state_cur, word);
    // Bit k entered first, so it sits highest among the freshly shifted bits.
    for (int k = 0; k < CHUNK; k++) begin
      scr_word[k] = state_nxt[CHUNK-1-k];
    end
  end

endmodule

// File: rtl/scr86_stream_ctrl.sv
// Sequencing controller: seed handling, frame tracking and registered output for the scrambler.
module scr86_stream_ctrl
  import scr86_pkg::*;
#(
  parameter int unsigned FCNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_valid,
  input  logic [ST_W-1:0]      seed,
  input  logic                 auto_reseed,
  input  logic                 bypass,
  scr86_stream_ctrl_if.slave   strm,
  output logic [ST_W-1:0]      state_q,
  output logic [FCNT_W-1:0]    frame_cnt,
  output logic                 seeded
);

  fsm_e             fsm_q, fsm_d;
  logic [ST_W-1:0]  shadow_q;
  logic             pend_q;
  logic             out_valid_q;
  logic [CHUNK-1:0] out_data_q;
  logic             out_last_q;

  logic             in_ready_c;
  logic             accept;
  logic             load_seed;
  logic             load_pend;
  logic [ST_W-1:0]  step_base;
  logic [ST_W-1:0]  step_nxt;
  logic [CHUNK-1:0] scr_word;

  assign strm.in_ready  = in_ready_c;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_last  = out_last_q;

  assign accept    = strm.in_valid & in_ready_c;
  assign load_seed = seed_valid & ((fsm_q == StIdle) | (fsm_q == StReady));
  assign load_pend = (fsm_q == StReady) & pend_q & ~seed_valid;
  // First word of a frame may be scrambled from the shadow seed instead of the running state.
  assign step_base = ((fsm_q == StReady) && auto_reseed) ? shadow_q : state_q;

  scr86_step u_step (
    .state_cur (step_base),
    .word      (strm.in_data),
    .state_nxt (step_nxt),
    .scr_word  (scr_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= StIdle;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      StIdle: begin
        if (seed_valid) fsm_d = StReady;
      end
      StReady: begin
        if (accept && !strm.in_last) fsm_d = StActive;
      end
      StActive: begin
        if (accept && strm.in_last) fsm_d = StReady;
      end
      default: fsm_d = StIdle;
    endcase
  end

  // Seed loads (direct or pending) own the state register, so data is held off that cycle.
  always_comb begin
    in_ready_c = 1'b0;
    case (fsm_q)
      StReady:  in_ready_c = (~out_valid_q | strm.out_ready) & ~seed_valid & ~pend_q;
      StActive: in_ready_c = ~out_valid_q | strm.out_ready;
      default:  in_ready_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= '0;
      shadow_q    <= '0;
      pend_q      <= 1'b0;
      seeded      <= 1'b0;
      frame_cnt   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (load_seed) begin
        state_q  <= seed;
        shadow_q <= seed;
        seeded   <= 1'b1;
        pend_q   <= 1'b0;
      end else if (load_pend) begin
        state_q <= shadow_q;
        pend_q  <= 1'b0;
      end else if (accept) begin
        state_q <= step_nxt;
      end

      if ((fsm_q == StActive) && seed_valid) begin
        shadow_q <= seed;
        pend_q   <= 1'b1;
      end

      if (accept && strm.in_last) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end

      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bypass ? strm.in_data : scr_word;
        out_last_q  <= strm.in_last;
      end else if (strm.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scr86_stream_ctrl.sv
// Directed and randomized bench for scr86_stream_ctrl against a word-level reference model.
module tb_scr86_stream_ctrl;
  import scr86_pkg::*;

  logic            clk;
  logic            rst;
  logic            seed_valid;
  logic [85:0]     seed;
  logic            auto_reseed;
  logic            bypass;
  logic [85:0]     state_q;
  logic [15:0]     frame_cnt;
  logic            seeded;

  scr86_stream_ctrl_if strm ();

  scr86_stream_ctrl #(.FCNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .seed_valid  (seed_valid),
    .seed        (seed),
    .auto_reseed (auto_reseed),
    .bypass      (bypass),
    .strm        (strm),
    .state_q     (state_q),
    .frame_cnt   (frame_cnt),
    .seeded      (seeded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_deliv  = 0;

  // Reference model: phase 0 = no seed, 1 = between frames, 2 = inside a frame.
  int          m_phase;
  logic [85:0] m_state, m_shadow;
  bit          m_pend, m_seeded, m_ov;
  logic [15:0] m_cnt;
  logic [14:0] exp_d[$];
  bit          exp_l[$];
  bit          last_acc;
  bit          stall_prev;
  logic [14:0] data_prev;
  bit          last_prev;

  task automatic check_eq(input string tag, input logic [85:0] obs, input logic [85:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [85:0] ref_poly();
    logic [85:0] p;
    p = '0;
    p[32] = 1'b1; p[47] = 1'b1; p[56] = 1'b1; p[65] = 1'b1; p[78] = 1'b1;
    return p;
  endfunction

  function automatic logic [85:0] ref_next(input logic [85:0] s, input logic [14:0] d);
    logic [85:0] t;
    bit          msb;
    t = s;
    for (int k = 0; k < 15; k++) begin
      msb = t[85];
      t = t << 1;
      if (msb) t = t ^ ref_poly() ^ 86'd1;
      t[0] = t[0] ^ d[k];
    end
    return t;
  endfunction

  function automatic logic [14:0] ref_word(input logic [85:0] ns);
    logic [14:0] w;
    for (int k = 0; k < 15; k++) w[k] = ns[14-k];
    return w;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_state = '0; m_shadow = '0; m_pend = 0; m_seeded = 0; m_ov = 0; m_cnt = '0;
    exp_d.delete(); exp_l.delete();
    stall_prev = 0;
  endtask

  function automatic bit model_ready();
    bit free;
    free = !m_ov || strm.out_ready;
    if (m_phase == 1) return free && !seed_valid && !m_pend;
    if (m_phase == 2) return free;
    return 0;
  endfunction

  task automatic model_push(input logic [85:0] base);
    logic [85:0] nx;
    nx = ref_next(base, strm.in_data);
    exp_d.push_back(bypass ? strm.in_data : ref_word(nx));
    exp_l.push_back(strm.in_last);
    m_state = nx;
  endtask

  task automatic model_step(input bit acc);
    if (rst) begin
      model_reset();
      return;
    end
    if (acc) m_ov = 1;
    else if (strm.out_ready) m_ov = 0;
    case (m_phase)
      0: if (seed_valid) begin
        m_state = seed; m_shadow = seed; m_seeded = 1; m_phase = 1;
      end
      1: if (seed_valid) begin
        m_state = seed; m_shadow = seed; m_pend = 0;
      end else if (m_pend) begin
        m_state = m_shadow; m_pend = 0;
      end else if (acc) begin
        model_push(auto_reseed ? m_shadow : m_state);
        if (strm.in_last) m_cnt = m_cnt + 16'd1;
        else m_phase = 2;
      end
      default: begin
        if (acc) begin
          model_push(m_state);
          if (strm.in_last) begin
            m_cnt = m_cnt + 16'd1;
            m_phase = 1;
          end
        end
        if (seed_valid) begin
          m_shadow = seed; m_pend = 1;
        end
      end
    endcase
  endtask

  // Inputs are already driven; checks handshake, advances model, then checks registered outputs.
  task automatic cycle();
    bit rdy;
    #1;
    rdy = model_ready();
    check_eq("in_ready", strm.in_ready, rdy);
    check_eq("out_valid", strm.out_valid, m_ov);
    if (stall_prev) begin
      check_eq("hold_data", strm.out_data, data_prev);
      check_eq("hold_last", strm.out_last, last_prev);
    end
    if (strm.out_valid && strm.out_ready) begin
      if (exp_d.size() == 0) begin
        check_eq("out_unexpected", 1, 0);
      end else begin
        check_eq("out_data", strm.out_data, exp_d.pop_front());
        check_eq("out_last", strm.out_last, exp_l.pop_front());
      end
      n_deliv++;
    end
    stall_prev = strm.out_valid && !strm.out_ready && !rst;
    data_prev  = strm.out_data;
    last_prev  = strm.out_last;
    last_acc   = strm.in_valid && rdy;
    model_step(last_acc);
    @(negedge clk);
    check_eq("state_q", state_q, m_state);
    check_eq("frame_cnt", frame_cnt, m_cnt);
    check_eq("seeded", seeded, m_seeded);
  endtask

  task automatic idle_inputs();
    rst = 0; seed_valid = 0; auto_reseed = 0; bypass = 0;
    strm.in_valid = 0; strm.in_data = '0; strm.in_last = 0; strm.out_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 0;
  endtask

  task automatic load_seed(input logic [85:0] s);
    seed_valid = 1; seed = s;
    cycle();
    seed_valid = 0;
  endtask

  task automatic send(input logic [14:0] d, input bit last);
    strm.in_valid = 1; strm.in_data = d; strm.in_last = last;
    cycle();
    strm.in_valid = 0; strm.in_last = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [95:0] r96;
    logic [14:0] w [3];
    int          idx;
    int          deliv0;

    seed = '0;
    do_reset();

    // No seed: controller refuses data.
    strm.in_valid = 1; strm.in_data = 15'h1234;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_eq("noseed_rdy", strm.in_ready, 0);
      check_eq("noseed_ov", strm.out_valid, 0);
    end
    strm.in_valid = 0;

    do_reset();
    load_seed(86'h1);
    send(15'h0000, 1);
    check_eq("t2_state", state_q, 86'h8000);
    check_eq("t2_data", strm.out_data, 15'h0000);

    do_reset();
    load_seed(86'h0);
    send(15'h7FFF, 1);
    check_eq("t3_data", strm.out_data, 15'h7FFF);
    check_eq("t3_last", strm.out_last, 1);
    check_eq("t3_state", state_q, 86'h7FFF);
    check_eq("t3_fcnt", frame_cnt, 16'd1);

    do_reset();
    auto_reseed = 1;
    load_seed(86'h1);
    send(15'h0000, 1);
    check_eq("t4_state1", state_q, 86'h8000);
    send(15'h0000, 1);
    check_eq("t4_state2", state_q, 86'h8000);
    check_eq("t4_fcnt", frame_cnt, 16'd2);
    auto_reseed = 0;

    // Seed arriving mid-frame is deferred until the frame closes.
    do_reset();
    load_seed(86'h5);
    send(15'h0ABC, 0);
    seed_valid = 1; seed = 86'h0;
    send(15'h1357, 0);
    seed_valid = 0;
    send(15'h2468, 1);
    cycle();
    check_eq("t5_state", state_q, 86'h0);

    // Backpressure: only the output register fills, then everything drains in order.
    do_reset();
    load_seed(86'h3_0000_0000_DEAD_BEEF);
    w[0] = 15'h1111; w[1] = 15'h2222; w[2] = 15'h3333;
    idx = 0;
    strm.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      strm.in_valid = (idx < 3);
      strm.in_data  = w[idx < 3 ? idx : 0];
      strm.in_last  = (idx == 2);
      cycle();
      if (last_acc) idx++;
    end
    check_eq("bp_accepted", idx, 1);
    check_eq("bp_in_ready", strm.in_ready, 0);
    deliv0 = n_deliv;
    strm.out_ready = 1;
    for (int i = 0; i < 20 && !(idx == 3 && !strm.out_valid); i++) begin
      strm.in_valid = (idx < 3);
      strm.in_data  = w[idx < 3 ? idx : 0];
      strm.in_last  = (idx == 2);
      cycle();
      if (last_acc) idx++;
    end
    strm.in_valid = 0;
    check_eq("bp_delivered", n_deliv - deliv0, 3);
    check_eq("bp_queue_empty", exp_d.size(), 0);

    // Randomized traffic with occasional reseeds, bypass, stalls and resets.
    do_reset();
    load_seed(86'h1);
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(299) == 0);
      seed_valid    = ($urandom_range(39) == 0);
      r96           = {$urandom(), $urandom(), $urandom()};
      seed          = r96[85:0];
      auto_reseed   = ($urandom_range(3) == 0);
      bypass        = ($urandom_range(4) == 0);
      strm.in_valid = ($urandom_range(3) != 0);
      strm.in_data  = 15'($urandom());
      strm.in_last  = ($urandom_range(3) == 0);
      strm.out_ready = ($urandom_range(2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
